// File: rtl/regfile_scoreboard.sv
// 32x32 register file (r0 hard zero) with two bypassed read ports and a
// per-register pending-write scoreboard used by issue for RAW/WAW hold.

module regfile_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_inc,
  input  logic             i_dec_req,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec;

  // a writeback with nothing outstanding (e.g. after flush) must not wrap
  assign w_dec = i_dec_req && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst)                                       r_cnt <= '0;
    else if (i_flush)                              r_cnt <= '0;
    else if (i_inc && !w_dec && (r_cnt != MAX))    r_cnt <= r_cnt + 1'b1;
    else if (!i_inc && w_dec)                      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;

  a_no_inc_at_max: assert property (@(posedge clk) disable iff (rst)
    !(i_inc && !w_dec && (r_cnt == MAX)));
endmodule

module regfile_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_idx,
  input  logic        wb_we,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs0_idx,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] rs0_data,
  output logic [31:0] rs1_data,
  output logic        rs0_busy,
  output logic        rs1_busy,
  input  logic        issue_valid,
  input  logic        issue_we,
  input  logic [4:0]  issue_rd,
  output logic        issue_full,
  input  logic        flush_i
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [31:0][31:0]      r_regs;
  logic [31:0][CNT_W-1:0] w_pend;
  logic                   w_inc;

  always_ff @(posedge clk) begin
    if (rst)                           r_regs <= '0;
    else if (wb_we && (wb_idx != 5'd0)) r_regs[wb_idx] <= wb_data;
  end

  assign w_inc     = issue_valid && issue_we;
  assign w_pend[0] = '0;

  for (genvar g = 1; g < 32; g++) begin : g_cnt
    regfile_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (flush_i),
      .i_inc     (w_inc && (issue_rd == 5'(g))),
      .i_dec_req (wb_we && (wb_idx == 5'(g))),
      .o_cnt     (w_pend[g])
    );
  end

  function automatic logic [31:0] f_rd(input logic [4:0] idx);
    if (idx == 5'd0)                 return 32'd0;
    else if (wb_we && wb_idx == idx) return wb_data;
    else                             return r_regs[idx];
  endfunction

  // a count of one landing this very cycle is already covered by the bypass
  function automatic logic f_busy(input logic [4:0] idx);
    logic w_hit;
    w_hit = wb_we && (wb_idx == idx);
    return (idx != 5'd0) &&
           ((w_pend[idx] > CNT_W'(1)) || ((w_pend[idx] == CNT_W'(1)) && !w_hit));
  endfunction

  assign rs0_data   = f_rd(rs0_idx);
  assign rs1_data   = f_rd(rs1_idx);
  assign rs0_busy   = f_busy(rs0_idx);
  assign rs1_busy   = f_busy(rs1_idx);
  assign issue_full = (issue_rd != 5'd0) && (w_pend[issue_rd] == MAX);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table for the scoreboard corner cases, then random traffic
// checked against an array-based model of the register file and pend counts.

module tb_regfile_scoreboard;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_idx, rs0_idx, rs1_idx, issue_rd;
  logic        wb_we, issue_valid, issue_we, flush_i;
  logic [31:0] wb_data, rs0_data, rs1_data;
  logic        rs0_busy, rs1_busy, issue_full;

  always #5 clk = ~clk;

  regfile_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wb_idx(wb_idx), .wb_we(wb_we), .wb_data(wb_data),
    .rs0_idx(rs0_idx), .rs1_idx(rs1_idx), .rs0_data(rs0_data), .rs1_data(rs1_data),
    .rs0_busy(rs0_busy), .rs1_busy(rs1_busy), .issue_valid(issue_valid),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_full(issue_full), .flush_i(flush_i)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic [4:0]  r0, r1;
    logic        iss;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] d0, d1;
    logic        b0, b1, full;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  function automatic vec_t mk(logic r, logic we, logic [4:0] widx, logic [31:0] wd,
                              logic [4:0] r0, logic [4:0] r1, logic iss, logic [4:0] ird,
                              logic fl, logic [31:0] d0, logic [31:0] d1,
                              logic b0, logic b1, logic full);
    vec_t v;
    v.rst = r; v.we = we; v.widx = widx; v.wdata = wd; v.r0 = r0; v.r1 = r1;
    v.iss = iss; v.ird = ird; v.fl = fl; v.d0 = d0; v.d1 = d1;
    v.b0 = b0; v.b1 = b1; v.full = full;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, n, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] widx,
                       input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1,
                       input logic iss, input logic [4:0] ird, input logic fl);
    rst = r; wb_we = we; wb_idx = widx; wb_data = wd; rs0_idx = r0; rs1_idx = r1;
    issue_valid = iss; issue_we = iss; issue_rd = ird; flush_i = fl;
  endtask

  // reference model state
  logic [31:0] m_reg [32];
  int          m_pend[32];

  function automatic logic [31:0] m_rd(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_idx == idx) return wb_data;
    return m_reg[idx];
  endfunction

  function automatic logic m_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (m_pend[idx] >= 2) return 1'b1;
    return (m_pend[idx] == 1) && !(wb_we && wb_idx == idx);
  endfunction

  task automatic m_clock();
    if (rst) begin
      foreach (m_reg[i]) begin m_reg[i] = 0; m_pend[i] = 0; end
      return;
    end
    if (wb_we && wb_idx != 0) m_reg[wb_idx] = wb_data;
    if (flush_i) begin
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      int delta[32];
      foreach (delta[i]) delta[i] = 0;
      if (issue_valid && issue_we && issue_rd != 0) delta[issue_rd] += 1;
      if (wb_we && wb_idx != 0 && m_pend[wb_idx] > 0) delta[wb_idx] -= 1;
      foreach (m_pend[i]) begin
        m_pend[i] += delta[i];
        if (m_pend[i] > MAXC) m_pend[i] = MAXC;
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    //      rst we widx wdata         r0 r1 iss ird fl  d0            d1            b0 b1 full
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 31, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'hDEADBEEF, 0, 0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 1,  0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 1, 5, 32'h12345678, 5, 6,  0, 0, 0, 32'h12345678, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        5, 5,  0, 0, 0, 32'h12345678, 32'h12345678, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        7, 0,  1, 7, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        7, 0,  1, 7, 0, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        7, 7,  0, 7, 0, 32'h0,        32'h0,        1, 1, 0));
    vt.push_back(mk(0, 1, 7, 32'hAAAA0001, 7, 0,  0, 0, 0, 32'hAAAA0001, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 1, 7, 32'hAAAA0002, 7, 7,  0, 0, 0, 32'hAAAA0002, 32'hAAAA0002, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        7, 0,  0, 0, 0, 32'hAAAA0002, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 3, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 3, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 3, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        3, 0,  0, 3, 0, 32'h0,        32'h0,        1, 0, 1));
    vt.push_back(mk(0, 1, 3, 32'h33,       3, 0,  1, 3, 0, 32'h33,       32'h0,        1, 0, 1));
    vt.push_back(mk(0, 0, 0, 32'h0,        3, 0,  0, 3, 0, 32'h33,       32'h0,        1, 0, 1));
    vt.push_back(mk(0, 1, 3, 32'h34,       0, 0,  0, 3, 0, 32'h0,        32'h0,        0, 0, 1));
    vt.push_back(mk(0, 0, 0, 32'h0,        3, 0,  0, 3, 0, 32'h34,       32'h0,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 9, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 9, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        9, 0,  1, 9, 1, 32'h0,        32'h0,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        9, 0,  0, 9, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 1, 9, 32'h99,       9, 0,  0, 0, 0, 32'h99,       32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        9, 9,  0, 9, 0, 32'h99,       32'h99,       0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 4, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0,  1, 4, 0, 32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(1, 1, 4, 32'hFF,       4, 4,  0, 4, 0, 32'hFF,       32'hFF,       1, 1, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        4, 5,  0, 4, 0, 32'h0,        32'h0,        0, 0, 0));

    foreach (vt[n]) begin
      drive(vt[n].rst, vt[n].we, vt[n].widx, vt[n].wdata, vt[n].r0, vt[n].r1,
            vt[n].iss, vt[n].ird, vt[n].fl);
      #1;
      chk("vec_rs0_data", n, rs0_data, vt[n].d0);
      chk("vec_rs1_data", n, rs1_data, vt[n].d1);
      chk("vec_rs0_busy", n, 32'(rs0_busy), 32'(vt[n].b0));
      chk("vec_rs1_busy", n, 32'(rs1_busy), 32'(vt[n].b1));
      chk("vec_issue_full", n, 32'(issue_full), 32'(vt[n].full));
      @(posedge clk);
      @(negedge clk);
    end

    // after reset every register reads zero with no busy
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); m_clock(); @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);
      #1;
      chk("rst_rd0", i, rs0_data, 32'h0);
      chk("rst_rd1", i, rs1_data, 32'h0);
      chk("rst_busy", i, 32'({rs0_busy, rs1_busy}), 32'h0);
      @(negedge clk);
    end

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ird;
      logic       iss, rr;
      ird = 5'($urandom_range(0, 7));
      iss = ($urandom_range(0, 2) != 0);
      if (m_pend[ird] == MAXC) iss = 1'b0;
      rr  = ($urandom_range(0, 199) == 0);
      drive(rr, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), iss, ird,
            ($urandom_range(0, 59) == 0));
      #1;
      chk("rnd_rs0_data", n, rs0_data, m_rd(rs0_idx));
      chk("rnd_rs1_data", n, rs1_data, m_rd(rs1_idx));
      chk("rnd_rs0_busy", n, 32'(rs0_busy), 32'(m_busy(rs0_idx)));
      chk("rnd_rs1_busy", n, 32'(rs1_busy), 32'(m_busy(rs1_idx)));
      chk("rnd_issue_full", n, 32'(issue_full),
          32'((issue_rd != 0) && (m_pend[issue_rd] == MAXC)));
      @(posedge clk);
      m_clock();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
